// File: rtl/parity_pkg.sv
// parity_pkg
// Shared definitions for the streaming parity block:
//   - state_e   : frame FSM states (ACC accepting beats, DONE result held)
//   - PAR_EVEN / PAR_ODD : parity sense constants
//   - sat_inc() : saturating increment for counters up to 32 bits wide
package parity_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Increment v, holding at the all-ones value of a w-bit counter.
  // Counters wider than 32 bits are not supported.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    if (w >= 32) begin
      max_v = 32'hFFFF_FFFF;
    end else begin
      max_v = (32'd1 << w) - 32'd1;
    end
    if (v >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/parity_tree.sv
// parity_tree
// Combinational XOR reduction of a DATA_W-bit word built as a balanced
// binary tree (heap-indexed, leaves padded with zeros to a power of two).
// Ports:
//   data   in  DATA_W  word to reduce
//   parity out 1       XOR of all bits of data
module parity_tree #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  localparam int LEAVES = 1 << $clog2(DATA_W);

  // node_s[1] is the root; node_s[LEAVES+i] is leaf i
  logic node_s [1:2*LEAVES-1];

  genvar gi;
  generate
    for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
      if (gi < DATA_W) begin : g_bit
        assign node_s[LEAVES+gi] = data[gi];
      end else begin : g_pad
        assign node_s[LEAVES+gi] = 1'b0;
      end
    end
    for (gi = 1; gi < LEAVES; gi++) begin : g_node
      assign node_s[gi] = node_s[2*gi] ^ node_s[2*gi+1];
    end
  endgenerate

  assign parity = node_s[1];

endmodule

// File: rtl/parity_stream.sv
// parity_stream
// Streaming parity generator/checker. Accumulates parity over multi-beat
// frames (valid/ready in), then holds one result per frame (valid/ready out).
// Optional feature macro: PARITY_ERR_CNT_EN enables the saturating mismatch
// counter on err_cnt; when undefined err_cnt is tied to zero.
// Ports:
//   clk, rst                 clock, async active-high reset
//   s_valid/s_ready          input beat handshake
//   s_data, s_last           input word and end-of-frame marker
//   check_en, par_in         expected-parity compare, sampled with last beat
//   m_valid/m_ready          frame result handshake
//   m_parity, m_beats, m_err frame parity, beat count (saturating), mismatch
//   err_clr, err_cnt         mismatch counter clear and value
module parity_stream
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter int ODD    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              check_en,
  input  logic              par_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_parity,
  output logic [CNT_W-1:0]  m_beats,
  output logic              m_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic ODD_BIT = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_e             state_r;
  logic               acc_r;
  logic [CNT_W-1:0]   beats_r;
  logic               word_par_s;
  logic               frame_par_s;
  logic [CNT_W-1:0]   beats_next_s;

  parity_tree #(.DATA_W(DATA_W)) u_tree (
    .data   (s_data),
    .parity (word_par_s)
  );

  assign frame_par_s  = acc_r ^ word_par_s ^ ODD_BIT;
  assign beats_next_s = CNT_W'(sat_inc(32'(beats_r), CNT_W));

  // Ready is purely a function of state so m_ready never reaches s_ready.
  assign s_ready = (state_r == ACC);

  // Frame FSM: accumulate beats in ACC, hold the registered result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ACC;
      acc_r    <= 1'b0;
      beats_r  <= {CNT_W{1'b0}};
      m_valid  <= 1'b0;
      m_parity <= 1'b0;
      m_beats  <= {CNT_W{1'b0}};
      m_err    <= 1'b0;
    end else begin
      case (state_r)
        ACC: begin
          if (s_valid) begin
            if (s_last) begin
              m_parity <= frame_par_s;
              m_beats  <= beats_next_s;
              m_err    <= check_en & (frame_par_s != par_in);
              m_valid  <= 1'b1;
              acc_r    <= 1'b0;
              beats_r  <= {CNT_W{1'b0}};
              state_r  <= DONE;
            end else begin
              acc_r    <= acc_r ^ word_par_s;
              beats_r  <= beats_next_s;
            end
          end
        end
        DONE: begin
          // Result outputs keep their last value; only valid drops.
          if (m_ready) begin
            m_valid <= 1'b0;
            state_r <= ACC;
          end
        end
        default: begin
          state_r <= ACC;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_r;

  // Mismatch counter: clear has priority over a same-cycle erroring handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (m_valid && m_ready && m_err) begin
      err_cnt_r <= CNT_W'(sat_inc(32'(err_cnt_r), CNT_W));
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic unused_err_clr_s;

  assign unused_err_clr_s = err_clr;
  assign err_cnt          = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_parity_stream.sv
// tb_parity_stream
// Directed bench: two instances share stimulus. dut_a uses the defaults
// (DATA_W=8, CNT_W=16, even parity); dut_b uses CNT_W=2 and odd parity so
// saturation and the ODD option are exercised on the same vectors.
module tb_parity_stream;

`ifdef PARITY_ERR_CNT_EN
  localparam logic CNT_ON = 1'b1;
`else
  localparam logic CNT_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       check_en;
  logic       par_in;
  logic       m_ready;
  logic       err_clr;

  logic        s_ready_a, m_valid_a, m_parity_a, m_err_a;
  logic [15:0] m_beats_a, err_cnt_a;
  logic        s_ready_b, m_valid_b, m_parity_b, m_err_b;
  logic [1:0]  m_beats_b, err_cnt_b;

  int checks_n;
  int errors_n;

  parity_stream #(.DATA_W(8), .CNT_W(16), .ODD(0)) dut_a (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_data(s_data), .s_last(s_last), .check_en(check_en), .par_in(par_in),
    .m_valid(m_valid_a), .m_ready(m_ready), .m_parity(m_parity_a),
    .m_beats(m_beats_a), .m_err(m_err_a), .err_clr(err_clr), .err_cnt(err_cnt_a)
  );

  parity_stream #(.DATA_W(8), .CNT_W(2), .ODD(1)) dut_b (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_data(s_data), .s_last(s_last), .check_en(check_en), .par_in(par_in),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_parity(m_parity_b),
    .m_beats(m_beats_b), .m_err(m_err_b), .err_clr(err_clr), .err_cnt(err_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat; both instances must be ready beforehand.
  task automatic beat(input logic [7:0] d, input logic last, input logic ce, input logic pin);
    check("s_ready_a_pre", 32'(s_ready_a), 32'd1);
    check("s_ready_b_pre", 32'(s_ready_b), 32'd1);
    s_valid  = 1'b1;
    s_data   = d;
    s_last   = last;
    check_en = ce;
    par_in   = pin;
    tick();
    s_valid  = 1'b0;
    s_last   = 1'b0;
    check_en = 1'b0;
    par_in   = 1'b0;
    s_data   = 8'h00;
  endtask

  task automatic expect_result(input string tag, input logic pa, input logic [15:0] ba, input logic ea,
                               input logic pb, input logic [1:0] bb, input logic eb);
    check({tag, "_valid_a"},  32'(m_valid_a),  32'd1);
    check({tag, "_valid_b"},  32'(m_valid_b),  32'd1);
    check({tag, "_par_a"},    32'(m_parity_a), 32'(pa));
    check({tag, "_beats_a"},  32'(m_beats_a),  32'(ba));
    check({tag, "_err_a"},    32'(m_err_a),    32'(ea));
    check({tag, "_par_b"},    32'(m_parity_b), 32'(pb));
    check({tag, "_beats_b"},  32'(m_beats_b),  32'(bb));
    check({tag, "_err_b"},    32'(m_err_b),    32'(eb));
    check({tag, "_sready_a"}, 32'(s_ready_a),  32'd0);
  endtask

  task automatic take(input logic clr);
    m_ready = 1'b1;
    err_clr = clr;
    tick();
    m_ready = 1'b0;
    err_clr = 1'b0;
    check("take_sready_a", 32'(s_ready_a), 32'd1);
    check("take_sready_b", 32'(s_ready_b), 32'd1);
    check("take_valid_a",  32'(m_valid_a), 32'd0);
  endtask

  initial begin
    checks_n = 0;
    errors_n = 0;
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    check_en = 1'b0; par_in = 1'b0; m_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_sready", 32'(s_ready_a), 32'd1);
    check("rst_valid",  32'(m_valid_a), 32'd0);
    check("rst_par",    32'(m_parity_a), 32'd0);
    check("rst_beats",  32'(m_beats_a), 32'd0);
    check("rst_err",    32'(m_err_a), 32'd0);
    check("rst_errcnt", 32'(err_cnt_a), 32'd0);

    // Single beat 0xA5 (4 ones); compare disabled despite par_in mismatch
    beat(8'hA5, 1'b1, 1'b0, 1'b1);
    expect_result("a5", 1'b0, 16'd1, 1'b0, 1'b1, 2'd1, 1'b0);
    take(1'b0);

    // Frame 0x01, 0x03: even parity 1, odd parity 0
    beat(8'h01, 1'b0, 1'b0, 1'b0);
    check("mid_valid", 32'(m_valid_a), 32'd0);
    beat(8'h03, 1'b1, 1'b0, 1'b0);
    expect_result("f2", 1'b1, 16'd2, 1'b0, 1'b0, 2'd2, 1'b0);
    take(1'b0);

    // Backpressure: result held, input stalled; offered beats ignored
    beat(8'h07, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
      tick();
      expect_result("bp", 1'b1, 16'd1, 1'b0, 1'b0, 2'd1, 1'b0);
    end
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    take(1'b0);

    // Check enabled: 0x01 with par_in=0 -> dut_a mismatch, dut_b match
    beat(8'h01, 1'b1, 1'b1, 1'b0);
    expect_result("chk", 1'b1, 16'd1, 1'b1, 1'b0, 2'd1, 1'b0);
    take(1'b0);
    check("errcnt_a_1", 32'(err_cnt_a), CNT_ON ? 32'd1 : 32'd0);
    check("errcnt_b_0", 32'(err_cnt_b), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errcnt_a_clr", 32'(err_cnt_a), 32'd0);

    // Five frames erroring only on dut_b (par_in=1): 2-bit counter saturates
    for (int i = 0; i < 5; i++) begin
      beat(8'h01, 1'b1, 1'b1, 1'b1);
      expect_result("sat", 1'b1, 16'd1, 1'b0, 1'b0, 2'd1, 1'b1);
      take(1'b0);
    end
    check("errcnt_b_sat", 32'(err_cnt_b), CNT_ON ? 32'd3 : 32'd0);
    check("errcnt_a_0",   32'(err_cnt_a), 32'd0);

    // Clear wins over an erroring handshake in the same cycle
    beat(8'h01, 1'b1, 1'b1, 1'b1);
    take(1'b1);
    check("clr_wins_b", 32'(err_cnt_b), 32'd0);

    // Five-beat frame of 0x01: parity 1, dut_b beat count saturates at 3
    for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 1'b0, 1'b0);
    beat(8'h01, 1'b1, 1'b0, 1'b0);
    expect_result("b5", 1'b1, 16'd5, 1'b0, 1'b0, 2'd3, 1'b0);
    take(1'b0);

    // Reset mid-frame discards the partial accumulation
    beat(8'h01, 1'b0, 1'b0, 1'b0);
    beat(8'h01, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    check("rstmid_valid", 32'(m_valid_a), 32'd0);
    tick();
    beat(8'hFF, 1'b1, 1'b0, 1'b0);
    expect_result("rstmid", 1'b0, 16'd1, 1'b0, 1'b1, 2'd1, 1'b0);
    take(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule

// File: doc/parity_stream.md
# parity_stream

Streaming parity generator/checker, the parametrised successor of the byte-wide combinational parity function. Accumulates parity across multi-beat frames of DATA_W-bit words using a valid/ready handshake. Presents one result per frame: parity, beat count and an optional mismatch flag against a supplied expected parity. Sits between a word-oriented source (UART/link framer) and the frame consumer, with its own backpressure.

## Interface
- DATA_W, 8, data word width (≥1)
- CNT_W, 16, width of beat counter and error counter (≥2)
- ODD, 0, 0 = even parity (XOR of all bits), 1 = odd parity (inverted)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset; one clock, asynchronous, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DATA_W  input word
- s_last  in  1  final beat of frame
- check_en  in  1  compare against par_in; sampled with last beat
- par_in  in  1  expected frame parity; sampled with last beat
- m_valid  out  1  frame result valid
- m_ready  in  1  result consumed when m_valid & m_ready
- m_parity  out  1  frame parity (ODD applied)
- m_beats  out  CNT_W  beats in frame, saturating at all-ones
- m_err  out  1  check_en & (m_parity != par_in)
- err_clr  in  1  synchronous clear of err_cnt
- err_cnt  out  CNT_W  mismatch counter (see Configuration)

## Operation
- FSM, two states: ACC (accepting beats), DONE (result held).
- ACC: s_ready=1, m_valid=0. Beat accept: acc ← acc ^ (^s_data); beats ← sat(beats+1).
- Accept with s_last=1: register m_parity = acc ^ (^s_data) ^ ODD, m_beats = sat(beats+1), m_err, then clear acc/beats → DONE.
- DONE: s_ready=0, m_valid=1, result outputs stable. On m_ready → ACC. No result skid; next frame starts the cycle after the handshake.
- Single-beat frame (s_last on first beat) valid: m_beats=1.
- s_data/s_last/check_en/par_in ignored when not accepted.
- m_beats saturates at 2^CNT_W−1; parity still correct past saturation.
- m_err=0 whenever check_en was 0 on the last beat.

## Timing
- Reset values: state=ACC, acc=0, beats=0, s_ready=1 (combinational from state), m_valid=0, m_parity=0, m_beats=0, m_err=0, err_cnt=0.
- Latency: last beat accepted at edge N → m_valid high after edge N, until the edge with m_ready=1.
- Throughput: one beat/cycle in ACC; one idle input cycle per frame (DONE state) minimum.
- s_ready depends only on state (no combinational path from m_ready).
- Reset mid-frame: partial accumulation discarded, any held result dropped, err_cnt cleared.
- err_clr and an erroring handshake in the same cycle: clear wins, err_cnt=0.

## Configuration
- PARITY_ERR_CNT_EN defined: err_cnt increments (saturating at all-ones) on each m_valid & m_ready with m_err=1; err_clr clears it.
- Undefined: err_cnt tied to 0, err_clr ignored, no counter flops; m_err still produced.

## Structure
- Package parity_pkg: state enum (ACC, DONE), saturating-increment function, ODD/EVEN constants.
- Sub-module parity_tree: combinational XOR reduction of DATA_W bits (balanced tree), instantiated once on s_data.

## Test plan
- DATA_W=8, ODD=0: single beat 0xA5, s_last → next cycle m_valid=1, m_parity=0, m_beats=1, m_err=0.
- Frame 0x01, 0x03 (last), ODD=1 → m_parity=0, m_beats=2; with ODD=0 → m_parity=1.
- Backpressure: frame 0x07 (last), m_ready low 3 cycles → m_valid held, outputs stable, s_ready=0 for those cycles; m_ready=1 → s_ready=1 next cycle.
- Check: frame 0x01 (last), check_en=1, par_in=0 → m_err=1, err_cnt=1 after handshake (macro on); err_clr → err_cnt=0; macro off → err_cnt stays 0.
- CNT_W=2, macro on: 5 erroring frames → err_cnt=3; 5-beat frame → m_beats=3.
- Reset mid-frame: beats 0x01, 0x01, then rst pulse; new frame 0xFF (last) → m_parity=0, m_beats=1.
